// File: rtl/attn_qkv_loader.sv
// attn_qkv_loader: collects Q, K and V rows from a valid/ready stream into
// three DIM x D_K matrices, fires a one-cycle start pulse at attention once
// all three are full, then holds the matrices until attention reports done.
//
// state | meaning
// ------+--------------------------------------------------------------
// LOAD  | accepting rows; counters track the next row index per matrix
// FIRE  | all matrices full; one-cycle start pulse to attention
// BUSY  | attention running; rows refused, matrices frozen until done
module attn_qkv_loader #(
  parameter int D_W = 8,
  parameter int DIM = 16,
  parameter int D_K = 16
) (
  input  logic                                I_CLK,
  input  logic                                I_SYNC_RST,
  input  logic                                I_ROW_VLD,
  output logic                                O_ROW_RDY,
  input  logic [1:0]                          I_ROW_SEL,
  input  logic [D_K*D_W-1:0]                  I_ROW_DATA,
  input  logic                                I_ATTN_DONE,
  output logic                                O_ATTN_START,
  output logic [0:DIM-1][0:D_K-1][D_W-1:0]    O_MAT_Q,
  output logic [0:DIM-1][0:D_K-1][D_W-1:0]    O_MAT_K,
  output logic [0:DIM-1][0:D_K-1][D_W-1:0]    O_MAT_V,
  output logic                                O_BUSY,
  output logic                                O_ERR,
  output logic [7:0]                          O_JOB_CNT
);

  localparam int CNT_W = $clog2(DIM + 1);
  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIM - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FIRE = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt_q, cnt_k, cnt_v;
  logic [0:D_K-1][D_W-1:0] row_cols;
  logic accept;
  logic wr_q, wr_k, wr_v;
  logic drop;
  logic q_full_nxt, k_full_nxt, v_full_nxt;
  logic done_ack;

  // Beat qualification: which matrix (if any) takes the accepted row.
  always_comb begin
    accept = I_ROW_VLD && O_ROW_RDY;
    wr_q   = accept && (I_ROW_SEL == 2'd0) && (cnt_q != CNT_FULL);
    wr_k   = accept && (I_ROW_SEL == 2'd1) && (cnt_k != CNT_FULL);
    wr_v   = accept && (I_ROW_SEL == 2'd2) && (cnt_v != CNT_FULL);
    drop   = accept && !(wr_q || wr_k || wr_v);
    q_full_nxt = (cnt_q == CNT_FULL) || (wr_q && (cnt_q == CNT_LAST));
    k_full_nxt = (cnt_k == CNT_FULL) || (wr_k && (cnt_k == CNT_LAST));
    v_full_nxt = (cnt_v == CNT_FULL) || (wr_v && (cnt_v == CNT_LAST));
    done_ack   = (state == S_BUSY) && I_ATTN_DONE;
  end

  // Unpack the row payload so column j lands in matrix element [row][j].
  always_comb begin
    row_cols = '0;
    for (int j = 0; j < D_K; j++) begin
      row_cols[j] = I_ROW_DATA[j*D_W +: D_W];
    end
  end

  // State register.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) state <= S_LOAD;
    else            state <= state_nxt;
  end

  // Next-state logic: fire on the beat that completes the last matrix.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: if (accept && q_full_nxt && k_full_nxt && v_full_nxt) state_nxt = S_FIRE;
      S_FIRE: state_nxt = S_BUSY;
      S_BUSY: if (I_ATTN_DONE) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Output decode; ready is also masked by reset so no beat lands during it.
  always_comb begin
    O_ROW_RDY    = (state == S_LOAD) && !I_SYNC_RST;
    O_ATTN_START = (state == S_FIRE);
    O_BUSY       = (state != S_LOAD);
  end

  // Row counters: advance on writes, cleared when attention finishes.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST || done_ack) begin
      cnt_q <= '0;
      cnt_k <= '0;
      cnt_v <= '0;
    end else begin
      if (wr_q) cnt_q <= cnt_q + 1'b1;
      if (wr_k) cnt_k <= cnt_k + 1'b1;
      if (wr_v) cnt_v <= cnt_v + 1'b1;
    end
  end

  // Sticky drop flag and completed-job counter (wraps naturally at 8 bits).
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      O_ERR     <= 1'b0;
      O_JOB_CNT <= '0;
    end else begin
      if (drop)     O_ERR     <= 1'b1;
      if (done_ack) O_JOB_CNT <= O_JOB_CNT + 8'd1;
    end
  end

  // Matrix storage; contents persist across jobs and are simply overwritten.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      O_MAT_Q <= '0;
      O_MAT_K <= '0;
      O_MAT_V <= '0;
    end else begin
      if (wr_q) O_MAT_Q[cnt_q[IDX_W-1:0]] <= row_cols;
      if (wr_k) O_MAT_K[cnt_k[IDX_W-1:0]] <= row_cols;
      if (wr_v) O_MAT_V[cnt_v[IDX_W-1:0]] <= row_cols;
    end
  end

endmodule

// File: tb/tb_attn_qkv_loader.sv
// Self-checking bench for attn_qkv_loader against a row-list reference model.
module tb_attn_qkv_loader;

  localparam int D_W   = 8;
  localparam int DIM   = 16;
  localparam int D_K   = 16;
  localparam int ROW_W = D_K * D_W;

  logic I_CLK = 1'b0;
  logic I_SYNC_RST = 1'b1;
  logic I_ROW_VLD = 1'b0;
  logic O_ROW_RDY;
  logic [1:0] I_ROW_SEL = 2'd0;
  logic [ROW_W-1:0] I_ROW_DATA = '0;
  logic I_ATTN_DONE = 1'b0;
  logic O_ATTN_START;
  logic [0:DIM-1][0:D_K-1][D_W-1:0] O_MAT_Q, O_MAT_K, O_MAT_V;
  logic O_BUSY, O_ERR;
  logic [7:0] O_JOB_CNT;

  attn_qkv_loader #(.D_W(D_W), .DIM(DIM), .D_K(D_K)) dut (
    .I_CLK(I_CLK), .I_SYNC_RST(I_SYNC_RST),
    .I_ROW_VLD(I_ROW_VLD), .O_ROW_RDY(O_ROW_RDY),
    .I_ROW_SEL(I_ROW_SEL), .I_ROW_DATA(I_ROW_DATA),
    .I_ATTN_DONE(I_ATTN_DONE), .O_ATTN_START(O_ATTN_START),
    .O_MAT_Q(O_MAT_Q), .O_MAT_K(O_MAT_K), .O_MAT_V(O_MAT_V),
    .O_BUSY(O_BUSY), .O_ERR(O_ERR), .O_JOB_CNT(O_JOB_CNT)
  );

  always #5 I_CLK = ~I_CLK;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  // reference model: per-matrix row lists, job counter, sticky error
  logic [D_W-1:0] mdl [3][DIM][D_K];
  int  mcnt [3];
  bit  merr;
  int  mjob;
  bit  mloading;

  always @(negedge I_CLK) if (O_ATTN_START === 1'b1) start_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mats_bad();
    int bad = 0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < D_K; c++) begin
        if (O_MAT_Q[r][c] !== mdl[0][r][c]) bad++;
        if (O_MAT_K[r][c] !== mdl[1][r][c]) bad++;
        if (O_MAT_V[r][c] !== mdl[2][r][c]) bad++;
      end
    return bad;
  endfunction

  function automatic logic [ROW_W-1:0] rep(input logic [D_W-1:0] v);
    logic [ROW_W-1:0] d;
    for (int j = 0; j < D_K; j++) d[j*D_W +: D_W] = v;
    return d;
  endfunction

  function automatic logic [ROW_W-1:0] ramp();
    logic [ROW_W-1:0] d;
    for (int j = 0; j < D_K; j++) d[j*D_W +: D_W] = D_W'(j);
    return d;
  endfunction

  function automatic logic [ROW_W-1:0] rnd_row();
    logic [ROW_W-1:0] d;
    for (int j = 0; j < D_K; j++) d[j*D_W +: D_W] = D_W'($urandom);
    return d;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      mcnt[s] = 0;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < D_K; c++) mdl[s][r][c] = '0;
    end
    merr = 0;
    mjob = 0;
    mloading = 1;
  endtask

  // returns 1 when this beat completes the job
  function automatic bit model_accept(input int sel, input logic [ROW_W-1:0] data);
    if (sel == 3 || mcnt[sel] == DIM) begin
      merr = 1;
    end else begin
      for (int c = 0; c < D_K; c++) mdl[sel][mcnt[sel]][c] = data[c*D_W +: D_W];
      mcnt[sel]++;
    end
    if (mloading && mcnt[0] == DIM && mcnt[1] == DIM && mcnt[2] == DIM) begin
      mloading = 0;
      return 1;
    end
    return 0;
  endfunction

  task automatic do_reset();
    I_ROW_VLD   = 1'b0;
    I_ATTN_DONE = 1'b0;
    I_SYNC_RST  = 1'b1;
    @(negedge I_CLK);
    check("rdy_in_reset", {31'd0, O_ROW_RDY}, 0);
    @(posedge I_CLK);
    #1;
    model_reset();
    check("rst_start", {31'd0, O_ATTN_START}, 0);
    check("rst_busy", {31'd0, O_BUSY}, 0);
    check("rst_err", {31'd0, O_ERR}, 0);
    check("rst_job", {24'd0, O_JOB_CNT}, 0);
    check("rst_mats", mats_bad(), 0);
    I_SYNC_RST = 1'b0;
    #1;
    check("rst_rdy_after", {31'd0, O_ROW_RDY}, 1);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge I_CLK);
      #1;
    end
  endtask

  task automatic send_row(input int sel, input logic [ROW_W-1:0] data);
    bit got, r, fire;
    I_ROW_SEL  = sel[1:0];
    I_ROW_DATA = data;
    I_ROW_VLD  = 1'b1;
    got = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge I_CLK);
      r = O_ROW_RDY;
      @(posedge I_CLK);
      if (r) begin
        got = 1;
        break;
      end
    end
    #1;
    I_ROW_VLD = 1'b0;
    check("row_accepted", {31'd0, got}, 1);
    if (got) begin
      fire = model_accept(sel, data);
      check("start_after_row", {31'd0, O_ATTN_START}, {31'd0, fire});
    end
  endtask

  // called in the FIRE cycle; waits, then pulses done for done_len cycles
  task automatic finish_job(input int wait_cycles, input bit hold_vld, input int done_len);
    int bad = 0;
    check("fire_busy", {31'd0, O_BUSY}, 1);
    check("fire_rdy", {31'd0, O_ROW_RDY}, 0);
    if (hold_vld) I_ROW_VLD = 1'b1;
    for (int i = 0; i < wait_cycles; i++) begin
      @(posedge I_CLK);
      #1;
      if (i == 0) check("start_one_cycle", {31'd0, O_ATTN_START}, 0);
      if (O_ROW_RDY !== 1'b0 || O_BUSY !== 1'b1 || mats_bad() != 0) bad++;
    end
    check("busy_hold", bad, 0);
    I_ROW_VLD   = 1'b0;
    I_ATTN_DONE = 1'b1;
    @(posedge I_CLK);
    #1;
    for (int s = 0; s < 3; s++) mcnt[s] = 0;
    mjob = (mjob + 1) % 256;
    mloading = 1;
    check("done_rdy", {31'd0, O_ROW_RDY}, 1);
    check("done_busy", {31'd0, O_BUSY}, 0);
    check("done_job", {24'd0, O_JOB_CNT}, mjob);
    if (done_len > 1) begin
      idle(done_len - 1);
      check("long_done_job", {24'd0, O_JOB_CNT}, mjob);
    end
    I_ATTN_DONE = 1'b0;
  endtask

  initial begin
    int st0;
    model_reset();
    do_reset();

    // 1: Q, K, V in order, ramp payload, valid held high
    for (int s = 0; s < 3; s++)
      for (int r = 0; r < DIM; r++) send_row(s, ramp());
    check("t1_start", {31'd0, O_ATTN_START}, 1);
    check("t1_err", {31'd0, O_ERR}, 0);
    check("t1_mats", mats_bad(), 0);
    check("t1_cell_q", {24'd0, O_MAT_Q[3][7]}, 7);
    check("t1_cell_v", {24'd0, O_MAT_V[15][15]}, 15);
    finish_job(3, 0, 1);

    // 2: round-robin interleave with random gaps; multi-cycle done
    for (int r = 0; r < DIM; r++)
      for (int s = 0; s < 3; s++) begin
        idle($urandom_range(0, 3));
        send_row(s, rep(D_W'(r)));
      end
    check("t2_start", {31'd0, O_ATTN_START}, 1);
    check("t2_mats", mats_bad(), 0);
    check("t2_cell_k", {24'd0, O_MAT_K[9][2]}, 9);
    finish_job(4, 0, 3);

    // 3: overflow row and illegal select are accepted and dropped
    for (int r = 0; r < DIM; r++) send_row(0, rnd_row());
    send_row(0, rep(8'hAA));
    check("t3_err_ovf", {31'd0, O_ERR}, 1);
    send_row(3, rnd_row());
    check("t3_err_sel", {31'd0, O_ERR}, 1);
    check("t3_mats", mats_bad(), 0);
    for (int r = 0; r < DIM; r++) begin
      send_row(1, rnd_row());
      send_row(2, rnd_row());
    end
    check("t3_start", {31'd0, O_ATTN_START}, 1);
    check("t3_mats_done", mats_bad(), 0);
    finish_job(2, 0, 1);
    check("t3_err_sticky", {31'd0, O_ERR}, 1);

    // 4: busy with valid held; then second job overwrites with 0x55
    do_reset();
    for (int r = 0; r < DIM; r++)
      for (int s = 0; s < 3; s++) send_row(s, rnd_row());
    finish_job(100, 1, 1);
    check("t4_job1", {24'd0, O_JOB_CNT}, 1);
    for (int s = 0; s < 3; s++)
      for (int r = 0; r < DIM; r++) send_row(s, rep(8'h55));
    check("t4_mats55", mats_bad(), 0);
    check("t4_cell", {24'd0, O_MAT_V[0][0]}, 32'h55);
    finish_job(1, 0, 1);

    // 5: reset after 20 rows aborts; done in LOAD is ignored
    for (int i = 0; i < 20; i++) send_row(i % 3, rnd_row());
    st0 = start_cnt;
    do_reset();
    idle(2);
    check("t5_no_start", start_cnt - st0, 0);
    I_ATTN_DONE = 1'b1;
    idle(2);
    I_ATTN_DONE = 1'b0;
    check("t5_done_in_load", {24'd0, O_JOB_CNT}, 0);
    check("t5_busy", {31'd0, O_BUSY}, 0);
    for (int r = 0; r < DIM; r++)
      for (int s = 0; s < 3; s++) send_row(s, rnd_row());
    check("t5_start", {31'd0, O_ATTN_START}, 1);
    check("t5_mats", mats_bad(), 0);
    finish_job(2, 0, 1);

    // 6: 256 jobs, done 5 cycles after each start; job counter wraps
    do_reset();
    st0 = start_cnt;
    for (int job = 1; job <= 256; job++) begin
      for (int r = 0; r < DIM; r++)
        for (int s = 0; s < 3; s++) send_row(s, rnd_row());
      if (job == 1 || job == 256) check("t6_mats", mats_bad(), 0);
      finish_job(5, 0, 1);
      if (job == 255) check("t6_job255", {24'd0, O_JOB_CNT}, 255);
      if (job == 256) check("t6_job256", {24'd0, O_JOB_CNT}, 0);
    end
    check("t6_starts", start_cnt - st0, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
